axis_packet_arbiter: RTL and testbench
======================================

// Module: axis_packet_arbiter
// PURPOSE
//  Packet-level round-robin arbiter: shares one AXI-Stream master among NUM_PORTS AXIS slave requesters.
//  Sits in front of shared LDPC datapath resources (encoder/decoder cores), which accept one codeword stream at a time.
//  Grant holds for a whole packet (until tlast); streams are never interleaved.
// PARAMETERS
//  NUM_PORTS   4   number of requesters, 2..16
//  DATA_WIDTH  64  tdata width in bits, multiple of 8; tkeep width = DATA_WIDTH/8
// PORTS
//  aclk       in   1                      clock, all logic rising-edge
//  aresetn    in   1                      synchronous, active-low reset
//  s_tvalid   in   NUM_PORTS              per-requester tvalid
//  s_tready   out  NUM_PORTS              per-requester tready
//  s_tdata    in   NUM_PORTS*DATA_WIDTH   port i at [i*DATA_WIDTH +: DATA_WIDTH]
//  s_tkeep    in   NUM_PORTS*DATA_WIDTH/8 port i at [i*DATA_WIDTH/8 +: DATA_WIDTH/8]
//  s_tlast    in   NUM_PORTS              per-requester tlast
//  m_tvalid   out  1 | m_tready in 1 | m_tdata out DATA_WIDTH | m_tkeep out DATA_WIDTH/8 | m_tlast out 1
//  grant_idx  out  $clog2(NUM_PORTS)      index of current owner, valid while busy=1
//  busy       out  1                      1 while a packet is owned (state XFER)
// BEHAVIOUR
//  - Reset (aresetn=0 at a rising edge): state=IDLE; last_grant=NUM_PORTS-1 (port 0 wins first); grant_idx=0;
//    busy=0; m_tvalid=0; all s_tready=0. Reset mid-packet abandons the packet; no flush, no tlast emitted.
//  - States: IDLE -> XFER when any s_tvalid=1; grant = first set bit of s_tvalid searching
//    last_grant+1, last_grant+2, ... (mod NUM_PORTS). grant_idx registered; last_grant<=grant.
//    XFER -> IDLE on the cycle m_tvalid & m_tready & m_tlast.
//  - Arbitration latency: 1 cycle (request seen in IDLE, data passes from next cycle).
//    One IDLE bubble between packets, even when requests are back-to-back.
//  - In XFER: combinational pass-through of the granted port: m_tvalid=s_tvalid[g], m_tdata/tkeep/tlast from port g;
//    s_tready[g]=m_tready; s_tready[others]=0. In IDLE: m_tvalid=0, all s_tready=0.
//  - Data outputs (m_tdata/tkeep/tlast) are don't-care when m_tvalid=0; the bench checks them only on handshakes.
//  - AXIS rules are obeyed as slave and master: no combinational path from m_tready into m_tvalid.
//    The granted requester may drop tvalid mid-packet (gap); grant holds until its tlast handshake.
//  - Requests arriving while in XFER are only considered at the next IDLE; no request is lost.
//    Holding tvalid is the requester's duty.
//  - Single-beat packet (tlast on first beat): XFER lasts exactly one handshake cycle.
//  - Round-robin wrap: from last_grant=NUM_PORTS-1 the search starts at port 0.
//  - No starvation: with all ports requesting continuously, grants cycle 0,1,..,NUM_PORTS-1,0,...
// CONFIGURATION
//  AXIS_ARB_PKT_COUNT_EN defined:
//    Adds output pkt_count out NUM_PORTS*16: per-port 16-bit counter, +1 on each tlast handshake of that port.
//    Counters wrap at 0xFFFF->0 and reset to 0.
//  AXIS_ARB_PKT_COUNT_EN undefined: the port and all counter logic are absent; other behaviour is identical.
// STRUCTURE
//  axis_arb_pkg:
//    typedef enum logic {ARB_IDLE, ARB_XFER} arb_state_t
//    localparam int unsigned ARB_MAX_PORTS = 16
//    localparam int unsigned ARB_CNT_WIDTH = 16
//  Sub-module rr_arbiter #(N):
//    Combinational rotate-priority pick from (req, last_grant); outputs grant index and any_req.
//    Instantiated once. Muxing and the FSM stay in the top module.
// TESTING
//  1 Reset: hold aresetn=0 5 cycles with all s_tvalid=1 -> m_tvalid=0, s_tready=0, busy=0 throughout.
//  2 Single port 2, 4-beat packet, m_tready=1:
//    busy=1 one cycle after tvalid; 4 beats out unchanged with correct tkeep; busy=0 the cycle after tlast.
//  3 All 4 ports request 2-beat packets continuously -> grant order 0,1,2,3,0,1, one idle cycle between packets.
//  4 Port 1 owns the packet and port 3 raises tvalid mid-packet:
//    port 1 completes uninterrupted; s_tready[3]=0 until port 3 is granted next.
//  5 Backpressure: m_tready toggles 1,0,0,1 and the requester inserts a tvalid gap mid-packet
//    -> no beats lost or duplicated, grant held.
//  6 With AXIS_ARB_PKT_COUNT_EN: 3 packets from port 0, 1 from port 3 -> pkt_count[0]=3, [3]=1, others 0.

Source files
------------

// File: rtl/axis_arb_pkg.sv
// ============================================================================
//  Module   : axis_arb_pkg
//  Brief    : Shared types and constants for the AXI-Stream packet arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package axis_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_XFER = 1'b1
    } arb_state_t;

    localparam int unsigned ARB_MAX_PORTS = 16;
    localparam int unsigned ARB_CNT_WIDTH = 16;

endpackage : axis_arb_pkg

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
//  Module   : rr_arbiter
//  Brief    : Combinational rotate-priority pick; search starts one past last grant.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_grant_i,
    output logic [IW-1:0] grant_o,
    output logic          any_req_o
);

    logic        w_found;
    int unsigned w_base;
    int unsigned w_idx;

    always_comb begin
        grant_o = '0;
        w_found = 1'b0;
        w_base  = int'(last_grant_i);
        w_idx   = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            w_idx = (w_base + k) % N;
            if (!w_found && req_i[w_idx]) begin
                grant_o = w_idx[IW-1:0];
                w_found = 1'b1;
            end
        end
    end

    assign any_req_o = |req_i;

endmodule : rr_arbiter

`default_nettype wire

// File: rtl/axis_packet_arbiter.sv
// ============================================================================
//  Module   : axis_packet_arbiter
//  Brief    : Packet-level round-robin AXIS arbiter; grant held until tlast.
//             Optional per-port packet counters under AXIS_ARB_PKT_COUNT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_packet_arbiter
    import axis_arb_pkg::*;
#(
    parameter  int unsigned NUM_PORTS  = 4,
    parameter  int unsigned DATA_WIDTH = 64,
    localparam int unsigned KW         = DATA_WIDTH / 8,
    localparam int unsigned IW         = $clog2(NUM_PORTS)
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [NUM_PORTS-1:0]          s_tvalid,
    output logic [NUM_PORTS-1:0]          s_tready,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_PORTS*KW-1:0]       s_tkeep,
    input  logic [NUM_PORTS-1:0]          s_tlast,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic [DATA_WIDTH-1:0]         m_tdata,
    output logic [KW-1:0]                 m_tkeep,
    output logic                          m_tlast,
    output logic [IW-1:0]                 grant_idx,
    output logic                          busy
`ifdef AXIS_ARB_PKT_COUNT_EN
    ,
    output logic [NUM_PORTS*ARB_CNT_WIDTH-1:0] pkt_count
`endif
);

    arb_state_t          state_q, state_d;
    logic [IW-1:0]       grant_q, grant_d;
    logic [IW-1:0]       last_q,  last_d;
    logic [IW-1:0]       w_pick;
    logic                w_any_req;
    logic                w_last_hs;
    logic [DATA_WIDTH-1:0] w_data [NUM_PORTS];
    logic [KW-1:0]       w_keep [NUM_PORTS];

    generate
        for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
            assign w_data[i] = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            assign w_keep[i] = s_tkeep[i*KW +: KW];
        end
    endgenerate

    rr_arbiter #(
        .N (NUM_PORTS)
    ) u_rr_arbiter (
        .req_i        (s_tvalid),
        .last_grant_i (last_q),
        .grant_o      (w_pick),
        .any_req_o    (w_any_req)
    );

    // Pass-through of the owner; m_tvalid never depends on m_tready.
    always_comb begin
        m_tvalid = 1'b0;
        s_tready = '0;
        if (state_q == ARB_XFER) begin
            m_tvalid           = s_tvalid[grant_q];
            s_tready[grant_q]  = m_tready;
        end
    end

    assign m_tdata   = w_data[grant_q];
    assign m_tkeep   = w_keep[grant_q];
    assign m_tlast   = s_tlast[grant_q];
    assign w_last_hs = m_tvalid & m_tready & m_tlast;
    assign busy      = (state_q == ARB_XFER);
    assign grant_idx = grant_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            ARB_IDLE: begin
                if (w_any_req) begin
                    state_d = ARB_XFER;
                    grant_d = w_pick;
                    last_d  = w_pick;
                end
            end
            ARB_XFER: begin
                if (w_last_hs) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            last_q  <= IW'(NUM_PORTS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

`ifdef AXIS_ARB_PKT_COUNT_EN
    generate
        for (genvar i = 0; i < NUM_PORTS; i++) begin : g_cnt
            logic [ARB_CNT_WIDTH-1:0] cnt_q;

            always_ff @(posedge aclk) begin
                if (!aresetn) begin
                    cnt_q <= '0;
                end else if (w_last_hs && (grant_q == IW'(i))) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            assign pkt_count[i*ARB_CNT_WIDTH +: ARB_CNT_WIDTH] = cnt_q;
        end
    endgenerate
`endif

endmodule : axis_packet_arbiter

`default_nettype wire

// File: tb/tb_axis_packet_arbiter.sv
// ============================================================================
//  Module   : tb_axis_packet_arbiter
//  Brief    : Self-checking bench: queue-based scoreboard plus round-robin model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_packet_arbiter;

    localparam int NP = 4;
    localparam int DW = 64;
    localparam int KW = 8;

    logic               aclk = 1'b0;
    logic               aresetn = 1'b0;
    logic [NP-1:0]      s_tvalid = '0;
    logic [NP-1:0]      s_tready;
    logic [NP*DW-1:0]   s_tdata = '0;
    logic [NP*KW-1:0]   s_tkeep = '0;
    logic [NP-1:0]      s_tlast = '0;
    logic               m_tvalid;
    logic               m_tready = 1'b1;
    logic [DW-1:0]      m_tdata;
    logic [KW-1:0]      m_tkeep;
    logic               m_tlast;
    logic [1:0]         grant_idx;
    logic               busy;
`ifdef AXIS_ARB_PKT_COUNT_EN
    logic [NP*16-1:0]   pkt_count;
`endif

    always #5 aclk = ~aclk;

    axis_packet_arbiter #(
        .NUM_PORTS  (NP),
        .DATA_WIDTH (DW)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .s_tdata   (s_tdata),
        .s_tkeep   (s_tkeep),
        .s_tlast   (s_tlast),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tdata   (m_tdata),
        .m_tkeep   (m_tkeep),
        .m_tlast   (m_tlast),
        .grant_idx (grant_idx),
        .busy      (busy)
`ifdef AXIS_ARB_PKT_COUNT_EN
        ,
        .pkt_count (pkt_count)
`endif
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        int            gap;
    } beat_t;

    beat_t src_q [NP][$];
    beat_t exp_q [NP][$];

    int  n_cmp = 0;
    int  n_err = 0;
    bit  force_all = 1'b0;
    bit  rst_req = 1'b1;
    int  rdy_pat [$];
    int  rdy_i = 0;
    bit  hs [NP];
    bit  started [NP];
    int  gcnt [NP];
    int  seq = 0;

    // Model state: owner/last-grant per the round-robin rule, plus logs.
    bit  mdl_on = 1'b0;
    bit  m_busy = 1'b0;
    int  m_own = 0;
    int  m_last = NP - 1;
    int  cyc_n = 0;
    int  glog [$];
    int  tl_stamp [$];
    int  hs_cnt = 0;
    int  req_cyc = 0;
    int  mcnt [NP];
    int  want [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    // Requester and sink driver; inputs change 1 time unit after the edge.
    always @(posedge aclk) begin
        #1;
        aresetn  = !rst_req;
        m_tready = (rdy_pat.size() > 0) ? (rdy_pat[rdy_i % rdy_pat.size()] != 0) : 1'b1;
        rdy_i++;
        for (int p = 0; p < NP; p++) begin
            if (hs[p] && src_q[p].size() > 0) begin
                void'(src_q[p].pop_front());
                started[p] = 1'b0;
            end
            if (force_all) begin
                s_tvalid[p]          = 1'b1;
                s_tlast[p]           = 1'b0;
                s_tdata[p*DW +: DW]  = '0;
                s_tkeep[p*KW +: KW]  = '0;
            end else if (src_q[p].size() > 0) begin
                if (!started[p]) begin
                    started[p] = 1'b1;
                    gcnt[p]    = src_q[p][0].gap;
                end
                if (gcnt[p] > 0) begin
                    gcnt[p]--;
                    s_tvalid[p] = 1'b0;
                end else begin
                    s_tvalid[p]         = 1'b1;
                    s_tdata[p*DW +: DW] = src_q[p][0].data;
                    s_tkeep[p*KW +: KW] = src_q[p][0].keep;
                    s_tlast[p]          = src_q[p][0].last;
                end
            end else begin
                s_tvalid[p] = 1'b0;
                s_tlast[p]  = 1'b0;
            end
        end
    end

    // Compare process: checks outputs against the model, then advances it.
    always @(negedge aclk) begin
        logic [NP-1:0] exp_rdy;
        bit            do_hs;
        beat_t         e;
        do_hs = 1'b0;
        cyc_n++;
        for (int p = 0; p < NP; p++) hs[p] = s_tvalid[p] && s_tready[p];
        if (mdl_on) begin
            chk("busy", 64'(busy), 64'(m_busy));
            exp_rdy = '0;
            if (m_busy && m_tready) exp_rdy[m_own] = 1'b1;
            chk("s_tready", 64'(s_tready), 64'(exp_rdy));
            chk("m_tvalid", 64'(m_tvalid), m_busy ? 64'(s_tvalid[m_own]) : 64'd0);
            if (m_busy) chk("grant_idx", 64'(grant_idx), 64'(m_own));
            do_hs = m_busy && s_tvalid[m_own] && m_tready;
            if (do_hs) begin
                hs_cnt++;
                if (exp_q[m_own].size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL beat: unexpected beat from port %0d data %0h, none required", m_own, m_tdata);
                end else begin
                    e = exp_q[m_own].pop_front();
                    chk("m_tdata", m_tdata, e.data);
                    chk("m_tkeep", 64'(m_tkeep), 64'(e.keep));
                    chk("m_tlast", 64'(m_tlast), 64'(e.last));
                end
                if (s_tlast[m_own]) begin
                    tl_stamp.push_back(cyc_n);
                    mcnt[m_own]++;
                end
            end
`ifdef AXIS_ARB_PKT_COUNT_EN
            for (int p = 0; p < NP; p++)
                chk("pkt_count", 64'(pkt_count[p*16 +: 16]), 64'(mcnt[p] & 16'hFFFF));
`endif
        end
        if (!aresetn) begin
            mdl_on = 1'b1;
            m_busy = 1'b0;
            m_last = NP - 1;
            for (int p = 0; p < NP; p++) mcnt[p] = 0;
        end else if (m_busy) begin
            if (do_hs && s_tlast[m_own]) m_busy = 1'b0;
        end else if (|s_tvalid) begin
            for (int k = 1; k <= NP; k++) begin
                if (!m_busy && s_tvalid[(m_last + k) % NP]) begin
                    m_own  = (m_last + k) % NP;
                    m_busy = 1'b1;
                end
            end
            m_last  = m_own;
            req_cyc = cyc_n;
            glog.push_back(m_own);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge aclk);
        #3;
    endtask

    task automatic do_reset();
        rst_req = 1'b1;
        cyc(3);
        glog.delete();
        tl_stamp.delete();
        hs_cnt  = 0;
        rst_req = 1'b0;
        cyc(1);
    endtask

    task automatic send_pkt(input int p, input int n, input int gap_beat, input int gap_len);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.data = (64'(p) << 56) | (64'(seq) << 16) | 64'(k);
            b.keep = (k == n - 1) ? (8'h3F >> p) : 8'hFF;
            b.last = (k == n - 1);
            b.gap  = (k == gap_beat) ? gap_len : 0;
            src_q[p].push_back(b);
            exp_q[p].push_back(b);
        end
        seq++;
    endtask

    function automatic bit pending();
        for (int p = 0; p < NP; p++)
            if (src_q[p].size() > 0 || exp_q[p].size() > 0) return 1'b1;
        return m_busy;
    endfunction

    task automatic wait_done(input string nm, input int budget);
        int c;
        c = 0;
        while (pending() && c < budget) begin
            cyc(1);
            c++;
        end
        if (c >= budget) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: traffic still pending after %0d cycles, required done", nm, budget);
        end
        cyc(2);
    endtask

    task automatic chk_glog(input string nm);
        chk({nm, "_ngrants"}, 64'(glog.size()), 64'(want.size()));
        for (int i = 0; i < want.size() && i < glog.size(); i++)
            chk({nm, "_grant"}, 64'(glog[i]), 64'(want[i]));
    endtask

    initial begin
        // 1: reset held with every requester asserting tvalid
        force_all = 1'b1;
        rst_req   = 1'b1;
        cyc(6);
        chk("t1_busy", 64'(busy), 64'd0);
        chk("t1_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("t1_s_tready", 64'(s_tready), 64'd0);
        chk("t1_grant_idx", 64'(grant_idx), 64'd0);
        force_all = 1'b0;
        rst_req   = 1'b0;
        cyc(2);

        // 2: single 4-beat packet on port 2
        do_reset();
        send_pkt(2, 4, -1, 0);
        wait_done("t2", 50);
        want = {2};
        chk_glog("t2");
        chk("t2_beats", 64'(hs_cnt), 64'd4);
        if (tl_stamp.size() == 1) chk("t2_latency", 64'(tl_stamp[0] - req_cyc), 64'd4);
        else chk("t2_ntlast", 64'(tl_stamp.size()), 64'd1);

        // 3: all ports requesting, 2-beat packets, fair rotation
        do_reset();
        send_pkt(0, 2, -1, 0);
        send_pkt(0, 2, -1, 0);
        send_pkt(1, 2, -1, 0);
        send_pkt(1, 2, -1, 0);
        send_pkt(2, 2, -1, 0);
        send_pkt(3, 2, -1, 0);
        wait_done("t3", 100);
        want = {0, 1, 2, 3, 0, 1};
        chk_glog("t3");
        chk("t3_beats", 64'(hs_cnt), 64'd12);
        chk("t3_ntlast", 64'(tl_stamp.size()), 64'd6);
        for (int i = 1; i < tl_stamp.size(); i++)
            chk("t3_pkt_spacing", 64'(tl_stamp[i] - tl_stamp[i-1]), 64'd3);

        // 4: port 3 arrives while port 1 owns the stream
        do_reset();
        send_pkt(1, 4, -1, 0);
        cyc(2);
        send_pkt(3, 2, -1, 0);
        wait_done("t4", 60);
        want = {1, 3};
        chk_glog("t4");
        chk("t4_beats", 64'(hs_cnt), 64'd6);

        // 5: backpressure pattern and a requester gap mid-packet
        do_reset();
        rdy_pat = {1, 0, 0, 1};
        send_pkt(0, 5, 2, 2);
        wait_done("t5", 100);
        rdy_pat.delete();
        want = {0};
        chk_glog("t5");
        chk("t5_beats", 64'(hs_cnt), 64'd5);

        // 6: single-beat packets, wrap from port 3 back to port 0
        do_reset();
        send_pkt(0, 1, -1, 0);
        send_pkt(0, 1, -1, 0);
        send_pkt(0, 1, -1, 0);
        send_pkt(3, 2, -1, 0);
        wait_done("t6", 60);
        want = {0, 3, 0, 0};
        chk_glog("t6");
        chk("t6_beats", 64'(hs_cnt), 64'd5);
`ifdef AXIS_ARB_PKT_COUNT_EN
        chk("t6_cnt0", 64'(pkt_count[0 +: 16]), 64'd3);
        chk("t6_cnt1", 64'(pkt_count[16 +: 16]), 64'd0);
        chk("t6_cnt2", 64'(pkt_count[32 +: 16]), 64'd0);
        chk("t6_cnt3", 64'(pkt_count[48 +: 16]), 64'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_axis_packet_arbiter

`default_nettype wire
